mem_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port coefficient/result memory (active-low chip enable, registered read data, one-cycle read latency). It sits between the CORDIC core's memory port (requester 0) and the host/config port (requester 1). It accepts at most one access per cycle over a valid/ready handshake, drives a registered command onto the memory, and routes the returned read data to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single-port synchronous memory.
// Registers one command per cycle onto the memory and steers read data back to its issuer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic                  mem_cen,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  idle
);

    // Last-grant pointer: 1 means requester 1 was granted last, so requester 0 wins a tie.
    logic last_q, last_d;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Issue stage
    logic                  issue_valid_q, issue_valid_d;
    logic                  issue_wr_q, issue_wr_d;
    logic                  issue_tag_q, issue_tag_d;
    logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;
    logic [DATA_WIDTH-1:0] issue_wdata_q, issue_wdata_d;

    // Read-return stage
    logic                  ret_valid_q, ret_valid_d;
    logic                  ret_tag_q, ret_tag_d;

    always_comb begin
        grant0    = req0_valid & (~req1_valid | last_q);
        grant1    = req1_valid & ~grant0;
        accept    = grant0 | grant1;
        sel_wr    = grant1 ? req1_wr    : req0_wr;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        last_d        = last_q;
        issue_valid_d = 1'b0;
        issue_wr_d    = 1'b0;
        issue_tag_d   = 1'b0;
        issue_addr_d  = '0;
        issue_wdata_d = '0;
        if (accept) begin
            last_d        = grant1;
            issue_valid_d = 1'b1;
            issue_wr_d    = sel_wr;
            issue_tag_d   = grant1;
            issue_addr_d  = sel_addr;
            issue_wdata_d = sel_wdata;
        end
    end

    always_comb begin
        ret_valid_d = issue_valid_q & ~issue_wr_q;
        ret_tag_d   = issue_valid_q & issue_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q        <= 1'b1;
            issue_valid_q <= 1'b0;
            issue_wr_q    <= 1'b0;
            issue_tag_q   <= 1'b0;
            issue_addr_q  <= '0;
            issue_wdata_q <= '0;
            ret_valid_q   <= 1'b0;
            ret_tag_q     <= 1'b0;
        end else begin
            last_q        <= last_d;
            issue_valid_q <= issue_valid_d;
            issue_wr_q    <= issue_wr_d;
            issue_tag_q   <= issue_tag_d;
            issue_addr_q  <= issue_addr_d;
            issue_wdata_q <= issue_wdata_d;
            ret_valid_q   <= ret_valid_d;
            ret_tag_q     <= ret_tag_d;
        end
    end

    assign mem_cen   = ~issue_valid_q;
    assign mem_wr_en = issue_wr_q;
    assign mem_addr  = issue_addr_q;
    assign mem_wdata = issue_wdata_q;

    always_comb begin
        rsp0_valid = ret_valid_q & ~ret_tag_q;
        rsp1_valid = ret_valid_q & ret_tag_q;
        rsp0_rdata = rsp0_valid ? mem_rdata : '0;
        rsp1_rdata = rsp1_valid ? mem_rdata : '0;
    end

    assign idle = ~issue_valid_q & ~ret_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_cen, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          idle;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wr    (req0_wr),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wr    (req1_wr),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_cen    (mem_cen),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded while in reset, registered read data.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i == 5) ? 32'hDEADBEEF : 32'hC0DE0000 + i;
            mem_rdata <= '0;
        end else if (!mem_cen) begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            else           mem_rdata     <= mem[mem_addr];
        end
    end

    function automatic logic [DW-1:0] preload(input int a);
        return (a == 5) ? 32'hDEADBEEF : 32'hC0DE0000 + a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_reqs();
        rst_n = 0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cen", mem_cen, 1);
        check("rst_wren", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rsp0v", rsp0_valid, 0);
        check("rst_rsp1v", rsp1_valid, 0);
        check("rst_rsp0d", rsp0_rdata, 0);
        check("rst_idle", idle, 1);
        rst_n = 1;
        next_cycle();

        // Single read from requester 0
        req0_valid = 1; req0_addr = 6'h05;
        @(negedge clk);
        check("sr_ready0", req0_ready, 1);
        check("sr_ready1", req1_ready, 0);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check("sr_cen", mem_cen, 0);
        check("sr_addr", mem_addr, 6'h05);
        check("sr_wren", mem_wr_en, 0);
        check("sr_idle", idle, 0);
        check("sr_early", rsp0_valid, 0);
        next_cycle();
        @(negedge clk);
        check("sr_rsp0v", rsp0_valid, 1);
        check("sr_rsp0d", rsp0_rdata, 32'hDEADBEEF);
        check("sr_rsp1v", rsp1_valid, 0);
        check("sr_rsp1d", rsp1_rdata, 0);
        next_cycle();

        // Write then read same address from requester 1
        req1_valid = 1; req1_wr = 1; req1_addr = 6'h3F; req1_wdata = 32'h12345678;
        @(negedge clk);
        check("wr_ready1", req1_ready, 1);
        next_cycle();
        req1_wr = 0; req1_wdata = '0;
        @(negedge clk);
        check("wr_cen", mem_cen, 0);
        check("wr_wren", mem_wr_en, 1);
        check("wr_wdata", mem_wdata, 32'h12345678);
        check("rd_ready1", req1_ready, 1);
        next_cycle();
        clear_reqs();
        @(negedge clk);
        check("wr_norsp", rsp1_valid, 0);
        check("rd_wren", mem_wr_en, 0);
        next_cycle();
        @(negedge clk);
        check("war_rsp1v", rsp1_valid, 1);
        check("war_rsp1d", rsp1_rdata, 32'h12345678);
        check("war_rsp0v", rsp0_valid, 0);
        next_cycle();

        // Contention: grants alternate 0,1,0,1,0,1 starting with requester 0
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                req0_valid = 1; req0_addr = 6'h01;
                req1_valid = 1; req1_addr = 6'h02;
            end else begin
                clear_reqs();
            end
            @(negedge clk);
            if (k < 6) begin
                check($sformatf("ct_ready0_%0d", k), req0_ready, (k % 2) == 0);
                check($sformatf("ct_ready1_%0d", k), req1_ready, (k % 2) == 1);
            end
            if (k >= 2) begin
                check($sformatf("ct_rsp0v_%0d", k), rsp0_valid, (k % 2) == 0);
                check($sformatf("ct_rsp1v_%0d", k), rsp1_valid, (k % 2) == 1);
                if ((k % 2) == 0) check($sformatf("ct_rsp0d_%0d", k), rsp0_rdata, 32'hC0DE0001);
                else              check($sformatf("ct_rsp1d_%0d", k), rsp1_rdata, 32'hC0DE0002);
            end
            next_cycle();
        end

        // Streaming: 16 reads from requester 0, addresses 0..15
        for (int k = 0; k < 19; k++) begin
            if (k < 16) begin
                req0_valid = 1; req0_addr = AW'(k);
            end else begin
                clear_reqs();
            end
            @(negedge clk);
            if (k < 16) check($sformatf("st_ready_%0d", k), req0_ready, 1);
            if (k >= 2 && k <= 17) begin
                check($sformatf("st_rsp0v_%0d", k), rsp0_valid, 1);
                check($sformatf("st_rsp0d_%0d", k), rsp0_rdata, preload(k - 2));
            end
            if (k >= 1 && k <= 17) check($sformatf("st_idle_%0d", k), idle, 0);
            if (k == 18) begin
                check("st_idle_end", idle, 1);
                check("st_rsp_end", rsp0_valid, 0);
            end
            next_cycle();
        end

        // Idle: no valids, pointer must still favour requester 1 afterwards
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("id_cen_%0d", k), mem_cen, 1);
            check($sformatf("id_ready0_%0d", k), req0_ready, 0);
            check($sformatf("id_ready1_%0d", k), req1_ready, 0);
            next_cycle();
        end
        req0_valid = 1; req0_addr = 6'h00;
        req1_valid = 1; req1_addr = 6'h00;
        @(negedge clk);
        check("id_tie_ready0", req0_ready, 0);
        check("id_tie_ready1", req1_ready, 1);
        next_cycle();
        req1_valid = 0;
        @(negedge clk);
        check("id_next_ready0", req0_ready, 1);
        next_cycle();
        clear_reqs();
        repeat (3) next_cycle();

        // Reset mid-read: pointer is 0 here, reset must restore requester-0 priority
        req0_valid = 1; req0_addr = 6'h07;
        @(negedge clk);
        check("rr_ready0", req0_ready, 1);
        next_cycle();
        clear_reqs();
        rst_n = 0;
        @(negedge clk);
        check("rr_cen", mem_cen, 1);
        check("rr_idle", idle, 1);
        next_cycle();
        @(negedge clk);
        check("rr_rsp0v", rsp0_valid, 0);
        check("rr_rsp1v", rsp1_valid, 0);
        check("rr_idle2", idle, 1);
        next_cycle();
        rst_n = 1;
        next_cycle();
        req0_valid = 1; req0_addr = 6'h03;
        req1_valid = 1; req1_addr = 6'h04;
        @(negedge clk);
        check("rr_tie_ready0", req0_ready, 1);
        check("rr_tie_ready1", req1_ready, 0);
        next_cycle();
        clear_reqs();
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
